// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO slave: register offsets, FSM states
// and the wait-state counter width.
package gpio_pkg;

    localparam logic [4:0] OFF_DOUT  = 5'h00;
    localparam logic [4:0] OFF_DIR   = 5'h04;
    localparam logic [4:0] OFF_DIN   = 5'h08;
    localparam logic [4:0] OFF_IE    = 5'h0C;
    localparam logic [4:0] OFF_ISTAT = 5'h10;

    localparam int WAIT_W = 4;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// Brings asynchronous pad inputs into the pclk domain and flags rising edges
// of the synchronised value.
module gpio_sync_edge #(
    parameter int NUM_GPIO = 32
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic [NUM_GPIO-1:0] din,
    output logic [NUM_GPIO-1:0] sync,
    output logic [NUM_GPIO-1:0] rise
);

    logic [NUM_GPIO-1:0] meta, sync_q, hist;

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            meta   <= '0;
            sync_q <= '0;
            hist   <= '0;
        end else begin
            meta   <= din;
            sync_q <= meta;
            hist   <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~hist;

endmodule

// File: rtl/apb_gpio_slave.sv
// APB3 slave front end and register file of the GPIO block: access FSM with
// programmable wait states, address decode, DOUT/DIR/IE/ISTAT registers, irq.
module apb_gpio_slave
    import gpio_pkg::*;
#(
    parameter int NUM_GPIO    = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [31:0]         paddr,
    input  logic [31:0]         pwdata,
    output logic [31:0]         prdata,
    output logic                pready,
    output logic                pslverr,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic [NUM_GPIO-1:0] gpio_out,
    output logic [NUM_GPIO-1:0] gpio_oe,
    output logic                irq
);

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wcnt, wcnt_nxt;
    logic [4:0]          off;
    logic                addr_err, err, wr_en;
    logic [NUM_GPIO-1:0] wdata, w1c_mask;
    logic [NUM_GPIO-1:0] dout, dir, ie, istat, din_sync, rise;
    logic [31:0]         rdata;
    logic                unused_bits;

    assign unused_bits = &{1'b0, paddr[31:5], pwdata};

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_nxt = ACCESS;
                    wcnt_nxt  = WAIT_W'(WAIT_STATES);
                end
            end
            ACCESS: begin
                if (!psel || pready)
                    state_nxt = IDLE;
                else if (wcnt != '0)
                    wcnt_nxt = wcnt - 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pready = (state == ACCESS) && (wcnt == '0) && psel && penable;

    assign off      = paddr[4:0];
    assign addr_err = (off[1:0] != 2'b00) || (off > OFF_ISTAT);
    assign err      = addr_err || (pwrite && off == OFF_DIN);
    assign pslverr  = pready && err;
    assign wr_en    = pready && pwrite && !err;
    assign wdata    = pwdata[NUM_GPIO-1:0];
    assign w1c_mask = (wr_en && off == OFF_ISTAT) ? wdata : '0;

    always_comb begin
        rdata = '0;
        case (off)
            OFF_DOUT:  rdata[NUM_GPIO-1:0] = dout;
            OFF_DIR:   rdata[NUM_GPIO-1:0] = dir;
            OFF_DIN:   rdata[NUM_GPIO-1:0] = din_sync;
            OFF_IE:    rdata[NUM_GPIO-1:0] = ie;
            OFF_ISTAT: rdata[NUM_GPIO-1:0] = istat;
            default:   rdata = '0;
        endcase
    end

    assign prdata = (pready && !pwrite && !err) ? rdata : 32'h0;

    gpio_sync_edge #(.NUM_GPIO(NUM_GPIO)) u_sync (
        .pclk   (pclk),
        .preset (preset),
        .din    (gpio_in),
        .sync   (din_sync),
        .rise   (rise)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            dout  <= '0;
            dir   <= '0;
            ie    <= '0;
            istat <= '0;
            irq   <= 1'b0;
        end else begin
            if (wr_en) begin
                case (off)
                    OFF_DOUT: dout <= wdata;
                    OFF_DIR:  dir  <= wdata;
                    OFF_IE:   ie   <= wdata;
                    default:  ;
                endcase
            end
            // A rise in the same cycle as a W1C keeps the bit set.
            istat <= rise | (istat & ~w1c_mask);
            irq   <= |(istat & ie);
        end
    end

    assign gpio_out = dout;
    assign gpio_oe  = dir;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// Directed bench for apb_gpio_slave: instance a has 32 pins / 0 wait states,
// instance b has 8 pins / 3 wait states; they share pclk, preset and bus wires.
module tb_apb_gpio_slave;

    logic        pclk = 1'b0;
    logic        preset = 1'b1;
    logic        psel_a = 1'b0, psel_b = 1'b0;
    logic        penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b, irq_a, irq_b;
    logic [31:0] gpio_in_a = '0;
    logic [7:0]  gpio_in_b = '0;
    logic [31:0] gpio_out_a, gpio_oe_a;
    logic [7:0]  gpio_out_b, gpio_oe_b;

    int errors = 0;
    int checks = 0;

    logic [31:0] rd;
    logic        er, rdy_after;
    int          w;

    always #5 pclk = ~pclk;

    apb_gpio_slave #(.NUM_GPIO(32), .WAIT_STATES(0)) dut_a (
        .pclk(pclk), .preset(preset), .psel(psel_a), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .pready(pready_a),
        .pslverr(pslverr_a), .gpio_in(gpio_in_a), .gpio_out(gpio_out_a),
        .gpio_oe(gpio_oe_a), .irq(irq_a)
    );

    apb_gpio_slave #(.NUM_GPIO(8), .WAIT_STATES(3)) dut_b (
        .pclk(pclk), .preset(preset), .psel(psel_b), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .pready(pready_b),
        .pslverr(pslverr_b), .gpio_in(gpio_in_b), .gpio_out(gpio_out_b),
        .gpio_oe(gpio_oe_b), .irq(irq_b)
    );

    // One complete transfer; waits = access cycles seen with pready low.
    task automatic apb(input bit sel_b, input logic [31:0] addr, input logic [31:0] data,
                       input bit wr, output logic [31:0] rdata, output logic slverr,
                       output int waits, output logic ready_after);
        @(posedge pclk); #1;
        if (sel_b) psel_b = 1'b1; else psel_a = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        @(posedge pclk); #1;
        penable = 1'b1;
        waits = 0;
        @(negedge pclk);
        while (!(sel_b ? pready_b : pready_a) && waits < 40) begin
            waits++;
            @(negedge pclk);
        end
        if (waits >= 40) begin
            checks++; errors++;
            $display("FAIL timeout addr=%h got no pready want pready within 40 cycles", addr);
        end
        rdata  = sel_b ? prdata_b : prdata_a;
        slverr = sel_b ? pslverr_b : pslverr_a;
        @(posedge pclk); #1;
        ready_after = sel_b ? pready_b : pready_a;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (pready_a !== 1'b0) begin errors++; $display("FAIL reset_pready got %b want 0", pready_a); end
        checks++; if (prdata_a !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h want 0", prdata_a); end
        checks++; if ({gpio_out_a, gpio_oe_a} !== 64'h0) begin errors++; $display("FAIL reset_gpio got %h want 0", {gpio_out_a, gpio_oe_a}); end
        checks++; if ({irq_a, irq_b, pslverr_a, pslverr_b} !== 4'h0) begin errors++; $display("FAIL reset_irq_err got %b want 0000", {irq_a, irq_b, pslverr_a, pslverr_b}); end
    endtask

    task automatic test_write_read();
        apb(0, 32'h0000_0000, 32'h0000_00A5, 1, rd, er, w, rdy_after);
        checks++; if (w !== 0 || er !== 1'b0) begin errors++; $display("FAIL wr_dout waits/err got %0d/%b want 0/0", w, er); end
        checks++; if (gpio_out_a !== 32'hA5) begin errors++; $display("FAIL wr_dout gpio_out got %h want 000000a5", gpio_out_a); end
        apb(0, 32'hFFFF_FF00, 32'h0, 0, rd, er, w, rdy_after);
        checks++; if (rd !== 32'hA5 || w !== 0) begin errors++; $display("FAIL rd_dout got %h/%0d want 000000a5/0", rd, w); end
        checks++; if (rdy_after !== 1'b0) begin errors++; $display("FAIL rd_dout_one_cycle pready got %b want 0", rdy_after); end
    endtask

    task automatic test_wait_states();
        apb(1, 32'h04, 32'h0000_003C, 1, rd, er, w, rdy_after);
        checks++; if (gpio_oe_b !== 8'h3C || w !== 3) begin errors++; $display("FAIL ws_dir got %h/%0d want 3c/3", gpio_oe_b, w); end
        apb(1, 32'h04, 32'h0, 0, rd, er, w, rdy_after);
        checks++; if (w !== 3) begin errors++; $display("FAIL ws_read waits got %0d want 3", w); end
        checks++; if (rd !== 32'h3C || er !== 1'b0) begin errors++; $display("FAIL ws_read data got %h/%b want 0000003c/0", rd, er); end
        checks++; if (rdy_after !== 1'b0) begin errors++; $display("FAIL ws_one_cycle pready got %b want 0", rdy_after); end
    endtask

    task automatic test_errors();
        apb(0, 32'h08, 32'hFFFF_FFFF, 1, rd, er, w, rdy_after);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_wr_din slverr got %b want 1", er); end
        apb(0, 32'h14, 32'h0, 0, rd, er, w, rdy_after);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_rd_14 got %b/%h want 1/0", er, rd); end
        apb(0, 32'h02, 32'h0, 0, rd, er, w, rdy_after);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_rd_02 slverr got %b want 1", er); end
        apb(0, 32'h01, 32'h0000_0000, 1, rd, er, w, rdy_after);
        checks++; if (er !== 1'b1 || gpio_out_a !== 32'hA5) begin errors++; $display("FAIL err_wr_01 got %b/%h want 1/000000a5", er, gpio_out_a); end
        apb(0, 32'h08, 32'h0, 0, rd, er, w, rdy_after);
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL din_after_err got %b/%h want 0/0", er, rd); end
    endtask

    task automatic test_width();
        apb(1, 32'h00, 32'hFFFF_FFFF, 1, rd, er, w, rdy_after);
        checks++; if (gpio_out_b !== 8'hFF) begin errors++; $display("FAIL width_out got %h want ff", gpio_out_b); end
        apb(1, 32'h00, 32'h0, 0, rd, er, w, rdy_after);
        checks++; if (rd !== 32'h0000_00FF) begin errors++; $display("FAIL width_read got %h want 000000ff", rd); end
    endtask

    task automatic test_irq();
        apb(0, 32'h0C, 32'h1, 1, rd, er, w, rdy_after);
        @(posedge pclk); #1;
        gpio_in_a[0] = 1'b1;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_early got %b want 0", irq_a); end
        @(posedge pclk); #1;
        checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq_a); end
        apb(0, 32'h10, 32'h0, 0, rd, er, w, rdy_after);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL istat_read got %h want 00000001", rd); end
        apb(0, 32'h08, 32'h0, 0, rd, er, w, rdy_after);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL din_read got %h want 00000001", rd); end
        apb(0, 32'h10, 32'h1, 1, rd, er, w, rdy_after);
        checks++; if (irq_a !== 1'b1) begin errors++; $display("FAIL irq_registered got %b want 1", irq_a); end
        @(posedge pclk); #1;
        checks++; if (irq_a !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq_a); end
        apb(0, 32'h10, 32'h0, 0, rd, er, w, rdy_after);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL istat_clear got %h want 0", rd); end
    endtask

    task automatic test_set_wins();
        gpio_in_a[0] = 1'b0;
        repeat (5) @(posedge pclk);
        @(posedge pclk); #1;
        gpio_in_a[0] = 1'b1;
        // Rise reaches ISTAT logic exactly on the commit edge of this W1C.
        apb(0, 32'h10, 32'h1, 1, rd, er, w, rdy_after);
        apb(0, 32'h10, 32'h0, 0, rd, er, w, rdy_after);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL set_wins istat got %h want 00000001", rd); end
    endtask

    task automatic test_reset_mid_access();
        @(posedge pclk); #1;
        psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h11;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        checks++; if (pready_b !== 1'b0) begin errors++; $display("FAIL mid_pready got %b want 0", pready_b); end
        preset = 1'b1;
        #1;
        checks++; if ({pready_b, pslverr_b, prdata_b, gpio_out_b, gpio_out_a} !== 74'h0) begin
            errors++; $display("FAIL mid_reset_outputs got %h want 0", {pready_b, pslverr_b, prdata_b, gpio_out_b, gpio_out_a});
        end
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;
        checks++; if (pready_b !== 1'b0 || gpio_out_b !== 8'h00) begin errors++; $display("FAIL mid_no_write got %b/%h want 0/00", pready_b, gpio_out_b); end
        psel_b = 1'b0; penable = 1'b0;
        apb(1, 32'h00, 32'h0, 0, rd, er, w, rdy_after);
        checks++; if (rd !== 32'h0 || w !== 3 || er !== 1'b0) begin errors++; $display("FAIL mid_next_xfer got %h/%0d/%b want 0/3/0", rd, w, er); end
    endtask

    initial begin
        repeat (3) @(posedge pclk);
        #1;
        test_reset();
        preset = 1'b0;
        test_write_read();
        test_wait_states();
        test_errors();
        test_width();
        test_irq();
        test_set_wins();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
